// File: rtl/string_delay_loop.sv
// Plucked-string delay loop: circular sample memory with averaging low-pass feedback and Q1.10 gain.
// Latency: sample_req -> sample_valid 4 cycles; requests arriving while busy are dropped, no backpressure.
module string_delay_loop #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    delay,
    input  logic [10:0]   filterMul,
    input  logic          pluck,
    input  logic [DW-1:0] excite_in,
    input  logic          sample_req,
    output logic [DW-1:0] sample_out,
    output logic          sample_valid,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {CLEAR, IDLE, RD0, RD1, MUL, WR, FILL} state_t;

    state_t        state, stateNext;
    logic [AW-1:0] wPtr;
    logic [9:0]    dEff;
    logic [9:0]    fillCnt;
    logic          pluckPend;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] x0, x1;

    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [DW-1:0] memWdata;
    logic          loadDeff;
    logic [9:0]    delayClamp;

    logic signed [DW:0]    sumW, avg;
    logic signed [DW+11:0] avgExt, gainExt, prod, shifted;
    logic [DW-1:0]         yVal;

    assign delayClamp = (delay < 10'd2) ? 10'd2 : delay;
    assign busy       = (state != IDLE);

    // Feedback: floor average, unsigned gain multiply, floor shift, then clamp to DW signed range
    assign sumW    = {x0[DW-1], x0} + {x1[DW-1], x1};
    assign avg     = sumW >>> 1;
    assign avgExt  = {{11{avg[DW]}}, avg};
    assign gainExt = {{(DW+1){1'b0}}, filterMul};
    assign prod    = avgExt * gainExt;
    assign shifted = prod >>> 10;

    always_comb begin
        yVal = shifted[DW-1:0];
        if (!((&shifted[DW+11:DW-1]) || !(|shifted[DW+11:DW-1]))) begin
            yVal = shifted[DW+11] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        stateNext = state;
        memAddr   = wPtr;
        memWe     = 1'b0;
        memWdata  = '0;
        loadDeff  = 1'b0;
        case (state)
            CLEAR: begin
                memWe = 1'b1;
                if (wPtr == AW'(DEPTH - 1)) stateNext = IDLE;
            end
            IDLE: begin
                if (pluck) begin
                    stateNext = FILL;
                    loadDeff  = 1'b1;
                end else if (sample_req) begin
                    stateNext = RD0;
                    loadDeff  = 1'b1;
                end
            end
            RD0: begin
                memAddr   = wPtr - dEff[AW-1:0];
                stateNext = RD1;
            end
            RD1: begin
                memAddr   = wPtr - dEff[AW-1:0] - AW'(1);
                stateNext = MUL;
            end
            MUL: stateNext = WR;
            WR: begin
                memWe    = 1'b1;
                memWdata = sample_out;
                if (pluckPend || pluck) begin
                    stateNext = FILL;
                    loadDeff  = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            FILL: begin
                memWe    = 1'b1;
                memWdata = excite_in;
                if (fillCnt == dEff - 10'd1) stateNext = IDLE;
            end
            default: stateNext = CLEAR;
        endcase
    end

    // Single-port delay memory: one read or one write per cycle, never both
    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memWdata;
        if (state == RD0) x0 <= mem[memAddr];
        if (state == RD1) x1 <= mem[memAddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            wPtr         <= '0;
            dEff         <= 10'd2;
            fillCnt      <= '0;
            pluckPend    <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= stateNext;
            sample_valid <= (state == MUL);
            if (memWe) wPtr <= wPtr + AW'(1);
            if (state == MUL) sample_out <= yVal;
            if (state == FILL) fillCnt <= fillCnt + 10'd1;
            if (loadDeff) begin
                dEff    <= delayClamp;
                fillCnt <= '0;
            end
            if (state == WR) begin
                pluckPend <= 1'b0;
            end else if (pluck && (state == RD0 || state == RD1 || state == MUL)) begin
                pluckPend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_string_delay_loop.sv
// Directed bench for string_delay_loop with a memory model and expected-sample scoreboard.
module tb_string_delay_loop;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  delay;
    logic [10:0] filterMul;
    logic        pluck;
    logic [15:0] excite_in;
    logic        sample_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;

    always #5 clk = ~clk;

    string_delay_loop #(.DEPTH(1024), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .delay(delay), .filterMul(filterMul),
        .pluck(pluck), .excite_in(excite_in), .sample_req(sample_req),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy)
    );

    int nChecks = 0;
    int nPass   = 0;
    int mMem [1024];
    int mW;
    int expQ [$];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        nChecks++;
        assert (got === exp) nPass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic int dEffOf(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int modelY(input int a, input int b, input int g);
        int avg, p, y;
        avg = (a + b) >>> 1;
        p   = avg * g;
        y   = p >>> 10;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic doReset(input string tag);
        int lat;
        rst_n = 1'b0; pluck = 1'b0; sample_req = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_out"}, $signed(sample_out), 0);
        for (int i = 0; i < 1024; i++) mMem[i] = 0;
        mW = 0;
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (!busy) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_clear_len"}, lat, 1024);
    endtask

    task automatic doSample(input int d, input int g, input string tag, input bit hasRef, input int refV);
        int deff, y, lat;
        deff = dEffOf(d);
        y = modelY(mMem[(mW - deff) & 1023], mMem[(mW - deff - 1) & 1023], g);
        mMem[mW] = y;
        mW = (mW + 1) & 1023;
        @(negedge clk);
        delay = 10'(d); filterMul = 11'(g); sample_req = 1'b1;
        expQ.push_back(hasRef ? refV : y);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            sample_req = 1'b0;
            delay = 10'($urandom_range(0, 1023));
            if (sample_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            chk({tag, "_timeout"}, 0, 1);
            void'(expQ.pop_front());
        end else begin
            chk({tag, "_latency"}, lat, 4);
            chk(tag, $signed(sample_out), expQ.pop_front());
        end
        @(negedge clk);
        chk({tag, "_strobe"}, sample_valid, 0);
    endtask

    task automatic doPluck(input int d, input int v0, input int step, input bit withReq,
                           input bit reqDuring, input string tag);
        int deff, fillLen;
        bit sawValid;
        logic [15:0] outBefore;
        deff = dEffOf(d);
        for (int i = 0; i < deff; i++) begin
            mMem[mW] = v0 + i * step;
            mW = (mW + 1) & 1023;
        end
        outBefore = sample_out;
        sawValid = 1'b0;
        fillLen = 0;
        @(negedge clk);
        delay = 10'(d); pluck = 1'b1; sample_req = withReq;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            pluck = 1'b0;
            sample_req = reqDuring && (k == 1);
            if (sample_valid) sawValid = 1'b1;
            if (!busy) begin
                fillLen = k;
                break;
            end
            excite_in = 16'(v0 + (k - 1) * step);
            delay = 10'($urandom_range(0, 1023));
        end
        repeat (6) begin
            @(negedge clk);
            if (sample_valid) sawValid = 1'b1;
        end
        chk({tag, "_fill_len"}, fillLen, deff + 1);
        chk({tag, "_out_hold"}, $signed(sample_out), $signed(outBefore));
        chk({tag, "_no_valid"}, sawValid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        int y, validAt, endAt;
        logic signed [31:0] outAt;
        delay = 10'd4; filterMul = 11'd1024; pluck = 1'b0; excite_in = '0; sample_req = 1'b0;
        rst_n = 1'b0;

        doReset("rst");
        doSample(5, 1024, "idle_zero", 1, 0);

        doPluck(4, 100, 100, 0, 0, "pluck4");
        doSample(4, 1024, "ks_a", 1, 50);
        doSample(4, 1024, "ks_b", 1, 150);

        doPluck(3, 32767, 0, 0, 0, "p_pos");
        doSample(2, 2047, "sat_pos", 1, 32767);
        doPluck(3, -32768, 0, 0, 0, "p_neg");
        doSample(2, 2047, "sat_neg", 1, -32768);
        doPluck(3, -3, 0, 0, 0, "p_m3");
        doSample(2, 1022, "floor", 1, -3);

        doPluck(2, 7, 1, 1, 0, "pluck_and_req");
        doPluck(5, -50, 20, 0, 1, "req_in_fill");

        doPluck(0, 11, 11, 0, 0, "d0");
        doSample(1, 1024, "d1", 1, 20);
        doSample(0, 1024, "d0_read", 0, 0);

        // Pluck arriving in MUL: sample completes, FILL follows WR with no IDLE gap
        y = modelY(mMem[(mW - 3) & 1023], mMem[(mW - 4) & 1023], 1024);
        mMem[mW] = y; mW = (mW + 1) & 1023;
        for (int i = 0; i < 3; i++) begin
            mMem[mW] = i + 1;
            mW = (mW + 1) & 1023;
        end
        @(negedge clk);
        delay = 10'd3; filterMul = 11'd1024; sample_req = 1'b1;
        expQ.push_back(y);
        validAt = 0; endAt = 0; outAt = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            sample_req = 1'b0;
            pluck = (k == 3);
            if (sample_valid && validAt == 0) begin
                validAt = k;
                outAt = $signed(sample_out);
            end
            if (k >= 2 && !busy && endAt == 0) endAt = k;
            if (k >= 5 && k <= 7) excite_in = 16'(k - 4);
        end
        chk("mul_pluck_latency", validAt, 4);
        chk("mul_pluck_sample", outAt, expQ.pop_front());
        chk("mul_pluck_fill_end", endAt, 8);
        doSample(3, 1024, "after_mul_pluck", 0, 0);

        doPluck(10, 1000, 500, 0, 0, "wrap_pluck");
        for (int i = 0; i < 1030; i++) doSample(10, 1023, "wrap", 0, 0);

        // Reset while a sample is in flight, then memory must read back cleared
        @(negedge clk);
        delay = 10'd2; sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        @(negedge clk);
        doReset("midop_rst");
        doSample(2, 1024, "post_reset", 1, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/string_delay_loop.md
STRING_DELAY_LOOP -- requirements
Module: string_delay_loop

Interface
REQ-001 Parameter DEPTH, default 1024, number of sample words in the circular delay memory; a power of two matching the 10-bit delay range.
REQ-002 Parameter DW, default 16, sample width in bits, signed two's complement.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 delay  input  10  loop length D in samples; same encoding as the gain-table address.
REQ-006 filterMul  input  11  unsigned feedback gain, Q1.10 (1024 = 1.0), driven by the gain table.
REQ-007 pluck  input  1  single-cycle request to load a new excitation into the loop.
REQ-008 excite_in  input  DW  signed excitation sample, consumed one per cycle during FILL.
REQ-009 sample_req  input  1  single-cycle request to compute one output sample.
REQ-010 sample_out  output  DW  signed output sample, held between updates.
REQ-011 sample_valid  output  1  one-cycle strobe; sample_out is updated on the same cycle.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: CLEAR, IDLE, RD0, RD1, MUL, WR, FILL.
REQ-014 CLEAR writes 0 to all DEPTH locations, one per cycle, starting at address 0; it takes DEPTH cycles, then the FSM goes to IDLE with wptr = 0.
REQ-015 Effective delay: Deff = max(delay, 2). It is latched on entry to RD0 or FILL and held constant for that operation.
REQ-016 IDLE: pluck has priority over sample_req; pluck -> FILL, else sample_req -> RD0.
REQ-017 RD0 reads x0 from address (wptr - Deff) mod DEPTH; RD1 reads x1 from address (wptr - Deff - 1) mod DEPTH.
REQ-018 MUL: avg = (x0 + x1) >>> 1 computed at 17 bits, then prod = avg * {1'b0, filterMul} as a signed 28-bit value, then y = prod >>> 10 (floor), saturated to the DW signed range.
REQ-019 WR writes y to address wptr, sets wptr = wptr + 1 mod DEPTH, loads sample_out = y, and pulses sample_valid; the FSM then returns to IDLE.
REQ-020 Latency: sample_req sampled in IDLE at cycle N -> sample_valid high at cycle N+4.
REQ-021 FILL writes excite_in to address wptr and increments wptr each cycle, for exactly Deff cycles, then returns to IDLE. sample_out does not change during FILL.
REQ-022 A sample_req that arrives while busy is dropped; it is not queued and produces no sample_valid.
REQ-023 A pluck that arrives during RD0..WR is latched into pluck_pend; FILL starts on the cycle after WR and pluck_pend is cleared. A pluck that arrives during FILL or CLEAR is ignored.
REQ-024 Changes to delay or filterMul mid-operation do not affect the operation in progress; filterMul is sampled in MUL.
REQ-025 wptr wraps from DEPTH-1 to 0 without a gap; read addresses use the same modulo arithmetic.
REQ-026 The delay memory is single-port: at most one read or one write per cycle.

Reset
REQ-027 While rst_n is low: sample_out = 0, sample_valid = 0, wptr = 0, pluck_pend = 0, FSM = CLEAR, busy = 1.
REQ-028 After rst_n deasserts, the CLEAR sequence of REQ-014 runs.
REQ-029 Reset asserted mid-operation aborts that operation immediately: no sample_valid, and memory is re-cleared afterwards.

Verification
REQ-030 Reset then wait: busy stays high for 1024 cycles after deassert, then drops; a sample_req returns sample_out = 0 with sample_valid 4 cycles later.
REQ-031 Pluck with delay = 4 and excite_in = 100, 200, 300, 400; then sample_req with filterMul = 1024 -> x0 = 100, x1 = 0 (cleared word at wptr - 5), so sample_out = 50; a second sample_req -> x0 = 200, x1 = 100, so sample_out = 150.
REQ-032 Gain and saturation: x0 = x1 = 32767 with filterMul = 2047 -> sample_out = 32767; x0 = x1 = -32768 with filterMul = 2047 -> sample_out = -32768; x0 = x1 = -3 with filterMul = 1022 -> sample_out = -3 (floor).
REQ-033 Wrap: run 1030 sample_reqs with delay = 10; read addresses crossing 1023 -> 0 match a reference model bit-exactly.
REQ-034 Simultaneous events: pluck and sample_req in the same IDLE cycle -> FILL only, no sample_valid. Pluck during MUL -> FILL begins the cycle after WR. sample_req during FILL -> dropped.
REQ-035 delay = 0 or 1 behaves exactly as delay = 2: FILL lasts 2 cycles and the read uses wptr - 2.
